// File: rtl/mem_stage_wb_if.sv
// EX/MEM-to-MEM/WB bus bundle: EX/MEM fields in, branch/stall and MEM/WB fields out.
// Latency: none (wires only).
// Backpressure: stall_out travels back to the upstream stages on this bundle.
interface mem_stage_wb_if;
  // EX/MEM fields
  logic [31:0] pc_branch_in;
  logic [31:0] alu_result_in;
  logic        alu_zero_in;
  logic [31:0] rt_data_in;
  logic [4:0]  r_target_in;
  logic        Branch_in;
  logic        Mem_Read_in;
  logic        Mem_Write_in;
  logic        Register_Write_in;
  logic        M2R_in;
  // Branch resolution and stall, back to the front end
  logic        pc_src_out;
  logic [31:0] pc_branch_out;
  logic        stall_out;
  // MEM/WB fields
  logic [31:0] mem_data_out;
  logic [31:0] alu_result_out;
  logic [4:0]  r_target_out;
  logic        Register_Write_out;
  logic        M2R_out;
  logic        align_err_out;

  // Upstream side: drives the EX/MEM fields, observes results
  modport master (
    output pc_branch_in, alu_result_in, alu_zero_in, rt_data_in, r_target_in,
           Branch_in, Mem_Read_in, Mem_Write_in, Register_Write_in, M2R_in,
    input  pc_src_out, pc_branch_out, stall_out, mem_data_out, alu_result_out,
           r_target_out, Register_Write_out, M2R_out, align_err_out
  );

  // MEM stage side
  modport slave (
    input  pc_branch_in, alu_result_in, alu_zero_in, rt_data_in, r_target_in,
           Branch_in, Mem_Read_in, Mem_Write_in, Register_Write_in, M2R_in,
    output pc_src_out, pc_branch_out, stall_out, mem_data_out, alu_result_out,
           r_target_out, Register_Write_out, M2R_out, align_err_out
  );
endinterface

// File: rtl/mem_stage_wb.sv
// MIPS MEM stage + MEM/WB register: data memory access, branch resolution, WB capture.
// Latency: MEM_LAT cycles for loads/stores, 1 cycle otherwise; branch/stall combinational.
// Backpressure: stall_out holds upstream while an access is in flight; WB gets bubbles meanwhile.
// Optional feature: define ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module mem_stage_wb #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  mem_stage_wb_if.slave bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [0:0] {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] mem_data_q, mem_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  r_target_q, r_target_d;
  logic        reg_write_q, reg_write_d;
  logic        m2r_q, m2r_d;
  logic        align_err_q, align_err_d;

  logic [31:0] mem [0:(2**ADDR_W)-1];

  logic              req;
  logic              stall;
  logic              misalign;
  logic              mem_we;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;

  assign req   = bus.Mem_Read_in | bus.Mem_Write_in;
  assign idx   = bus.alu_result_in[ADDR_W+1:2];
  assign stall = req & (cnt_q != LAST);

`ifdef ALIGN_CHECK_EN
  assign misalign = req & (bus.alu_result_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Commit the store exactly once, on the final access cycle; reset aborts it.
  assign mem_we = bus.Mem_Write_in & ~stall & ~misalign & ~rst;

  // Asynchronous read: a simultaneous store lands at the edge, so the load sees the old word.
  always_comb begin
    rd_word = mem[idx];
  end

  assign bus.stall_out     = stall;
  assign bus.pc_src_out    = bus.Branch_in & bus.alu_zero_in & ~stall;
  assign bus.pc_branch_out = bus.pc_branch_in;

  assign bus.mem_data_out       = mem_data_q;
  assign bus.alu_result_out     = alu_result_q;
  assign bus.r_target_out       = r_target_q;
  assign bus.Register_Write_out = reg_write_q;
  assign bus.M2R_out            = m2r_q;
  assign bus.align_err_out      = align_err_q;

  // Access FSM: count stall cycles while a request is pending, drop back to IDLE on the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (stall) begin
          state_d = BUSY;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (stall) begin
          state_d = BUSY;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // MEM/WB next values: capture when not stalled, otherwise hold with a write-enable bubble.
  always_comb begin
    mem_data_d   = mem_data_q;
    alu_result_d = alu_result_q;
    r_target_d   = r_target_q;
    reg_write_d  = 1'b0;
    m2r_d        = m2r_q;
    align_err_d  = align_err_q;
    if (!stall) begin
      mem_data_d   = bus.Mem_Read_in ? rd_word : 32'h0;
      alu_result_d = bus.alu_result_in;
      r_target_d   = bus.r_target_in;
      reg_write_d  = bus.Register_Write_in & ~misalign;
      m2r_d        = bus.M2R_in;
      align_err_d  = misalign;
    end
  end

  // State, counter and MEM/WB flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mem_data_q   <= '0;
      alu_result_q <= '0;
      r_target_q   <= '0;
      reg_write_q  <= 1'b0;
      m2r_q        <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_data_q   <= mem_data_d;
      alu_result_q <= alu_result_d;
      r_target_q   <= r_target_d;
      reg_write_q  <= reg_write_d;
      m2r_q        <= m2r_d;
      align_err_q  <= align_err_d;
    end
  end

  // Data memory array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= bus.rt_data_in;
    end
  end

endmodule
